decode_control_unit: RTL

- Multi-cycle instruction decode and control stage directly upstream of the ALU.
- Accepts one 32-bit instruction per transaction and decodes opcode, sub-opcode and register/immediate fields.
- Reads a 32x32 register file and drives opcode, sub_opcode, src1, src2 and enable_execute to the ALU.
- Captures alu_result/alu_overflow and performs the memory access and register writeback.

---
 rtl/decode_control_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/decode_control_unit.sv
// Multi-cycle decode/control stage feeding the ALU: latches one instruction,
// reads a 32x32 register file, sequences execute, data memory access and writeback.
module decode_control_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [5:0]        opcode,
  output logic [7:0]        sub_opcode,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic              enable_execute,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic [DATA_W-1:0] dm_addr,
  output logic              dm_read,
  output logic              dm_write,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              done,
  output logic              overflow_exc,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int AW = $clog2(REG_NUM);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXECUTE, S_MEM, S_WB
  } state_e;

  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_SHI, K_IMM, K_MOVI, K_LDI, K_STI, K_LD, K_ST
  } kind_e;

  function automatic kind_e decode_kind(input logic [5:0] op, input logic [7:0] sub);
    kind_e k;
    k = K_NOP;
    case (op)
      6'b100000: begin
        case (sub)
          8'h00, 8'h01, 8'h02, 8'h03, 8'h04: k = K_ALU;
          8'h08, 8'h09, 8'h0B:               k = K_SHI;
          default:                           k = K_NOP;
        endcase
      end
      6'b101000, 6'b101100, 6'b101011: k = K_IMM;
      6'b100010:                       k = K_MOVI;
      6'b000010:                       k = K_LDI;
      6'b001010:                       k = K_STI;
      6'b011100: begin
        if (sub == 8'h02)      k = K_LD;
        else if (sub == 8'h0A) k = K_ST;
        else                   k = K_NOP;
      end
      default: k = K_NOP;
    endcase
    return k;
  endfunction

  state_e            state;
  logic [5:0]        op_q;
  logic [7:0]        sub_q;
  logic [AW-1:0]     rt_q;
  logic [DATA_W-1:0] res_q;
  logic              ovf_q;
  logic [DATA_W-1:0] regs [REG_NUM];

  kind_e             kind_in, kind_q;
  logic [DATA_W-1:0] nxt_src1, nxt_src2;
  logic              is_load, is_store, is_write, ovf_op;
  logic              unused_bits;

  assign unused_bits = ^{instr[31], instr[9:8]};
  assign dbg_data    = regs[dbg_addr];

  assign kind_q   = decode_kind(op_q, sub_q);
  assign is_load  = (kind_q == K_LDI) || (kind_q == K_LD);
  assign is_store = (kind_q == K_STI) || (kind_q == K_ST);
  assign is_write = (kind_q == K_ALU) || (kind_q == K_SHI) || (kind_q == K_IMM) ||
                    (kind_q == K_MOVI) || is_load;
  // Only the signed adds can raise an exception that cancels the write.
  assign ovf_op   = ((kind_q == K_ALU) && (sub_q == 8'h00 || sub_q == 8'h01)) ||
                    (op_q == 6'b101000);

  // Operand selection from the incoming word, so operands are already on the
  // ALU bus throughout DECODE and held through EXECUTE.
  always_comb begin
    kind_in  = decode_kind(instr[30:25], instr[7:0]);
    nxt_src1 = '0;
    nxt_src2 = '0;
    case (kind_in)
      K_ALU, K_LD, K_ST: begin
        nxt_src1 = regs[instr[19:15]];
        nxt_src2 = regs[instr[14:10]];
      end
      K_SHI: begin
        nxt_src1 = regs[instr[19:15]];
        nxt_src2 = DATA_W'(instr[14:10]);
      end
      K_IMM, K_LDI, K_STI: begin
        nxt_src1 = regs[instr[19:15]];
        nxt_src2 = DATA_W'(instr[14:0]);
      end
      K_MOVI: nxt_src2 = DATA_W'(instr[19:0]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      instr_ready    <= 1'b1;
      op_q           <= '0;
      sub_q          <= '0;
      rt_q           <= '0;
      res_q          <= '0;
      ovf_q          <= 1'b0;
      opcode         <= '0;
      sub_opcode     <= '0;
      src1           <= '0;
      src2           <= '0;
      enable_execute <= 1'b0;
      dm_addr        <= '0;
      dm_read        <= 1'b0;
      dm_write       <= 1'b0;
      dm_wdata       <= '0;
      done           <= 1'b0;
      overflow_exc   <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      enable_execute <= 1'b0;
      dm_addr        <= '0;
      dm_read        <= 1'b0;
      dm_write       <= 1'b0;
      dm_wdata       <= '0;
      done           <= 1'b0;
      overflow_exc   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q        <= instr[30:25];
            sub_q       <= instr[7:0];
            rt_q        <= instr[24:20];
            opcode      <= instr[30:25];
            sub_opcode  <= instr[7:0];
            src1        <= nxt_src1;
            src2        <= nxt_src2;
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          enable_execute <= 1'b1;
          state          <= S_EXECUTE;
        end
        S_EXECUTE: begin
          res_q <= alu_result;
          ovf_q <= alu_overflow;
          if (is_load || is_store) begin
            dm_addr  <= alu_result;
            dm_read  <= is_load;
            dm_write <= is_store;
            dm_wdata <= is_store ? regs[rt_q] : '0;
            state    <= S_MEM;
          end else begin
            done         <= 1'b1;
            overflow_exc <= ovf_op && alu_overflow;
            state        <= S_WB;
          end
        end
        S_MEM: begin
          done  <= 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          // Load data arrives during WB, one cycle after the read strobe.
          if (is_write && !(ovf_op && ovf_q))
            regs[rt_q] <= is_load ? dm_rdata : res_q;
          opcode      <= '0;
          sub_opcode  <= '0;
          src1        <= '0;
          src2        <= '0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
